// File: rtl/vec_sweep_seq_if.sv
// Stimulus/response bundle between the exhaustive-sweep sequencer and its host.
// master: the sequencer itself; slave: the host that starts sweeps and supplies
// the downstream block's response.
interface vec_sweep_seq_if #(
    parameter int WIDTH = 5
);
    logic                  start;
    logic                  resp_in;
    logic [WIDTH-1:0]      vec;
    logic                  busy;
    logic                  done;
    logic [2**WIDTH-1:0]   truth;
    logic [WIDTH:0]        err_cnt;

    modport master (
        input  start,
        input  resp_in,
        output vec,
        output busy,
        output done,
        output truth,
        output err_cnt
    );

    modport slave (
        output start,
        output resp_in,
        input  vec,
        input  busy,
        input  done,
        input  truth,
        input  err_cnt
    );
endinterface

// File: rtl/vec_sweep_seq.sv
// Exhaustive sweep sequencer for the AOI block F = ~(((A&B)|C|D)&E).
// On start, counts vec through every code, holding each for DWELL clocks, and
// records the response sampled on the last clock of each dwell into truth.
// Optional macro VEC_GOLDEN_CHECK_EN (needs WIDTH==5): compares each sample
// with an internal golden AOI model and counts mismatches in err_cnt
// (saturating at 2**WIDTH). Without it err_cnt is constant zero.
module vec_sweep_seq #(
    parameter int WIDTH = 5,
    parameter int DWELL = 25
) (
    input  logic           clk,
    input  logic           rst,
    vec_sweep_seq_if.master sweep
);
    localparam int              DEPTH      = 2**WIDTH;
    localparam logic [1:0]      ST_IDLE    = 2'd0;
    localparam logic [1:0]      ST_DRIVE   = 2'd1;
    localparam logic [1:0]      ST_FIN     = 2'd2;
    localparam logic [15:0]     DWELL_LAST = 16'(DWELL - 1);
    localparam logic [WIDTH-1:0] VEC_LAST  = {WIDTH{1'b1}};

    logic [1:0]       state_reg, state_next;
    logic [WIDTH-1:0] vec_reg, vec_next;
    logic [15:0]      dwell_cnt_reg, dwell_cnt_next;
    logic [DEPTH-1:0] truth_reg, truth_next;
    logic             start_accept;
    logic             sample_point;

    assign start_accept = (state_reg == ST_IDLE) && sweep.start;
    // Last clock of a dwell: downstream logic has had DWELL-1 cycles to settle.
    assign sample_point = (state_reg == ST_DRIVE) && (dwell_cnt_reg == DWELL_LAST);

    // Sequencer next-state: vec advances only at dwell boundaries, and the
    // terminal check comes first so vec never wraps inside a sweep.
    always_comb begin
        state_next     = state_reg;
        vec_next       = vec_reg;
        dwell_cnt_next = dwell_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                vec_next       = '0;
                dwell_cnt_next = '0;
                if (sweep.start) begin
                    state_next = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (dwell_cnt_reg == DWELL_LAST) begin
                    if (vec_reg == VEC_LAST) begin
                        state_next = ST_FIN;
                    end else begin
                        vec_next       = vec_reg + 1'b1;
                        dwell_cnt_next = '0;
                    end
                end else begin
                    dwell_cnt_next = dwell_cnt_reg + 16'd1;
                end
            end
            ST_FIN: begin
                state_next     = ST_IDLE;
                vec_next       = '0;
                dwell_cnt_next = '0;
            end
            default: begin
                state_next     = ST_IDLE;
                vec_next       = '0;
                dwell_cnt_next = '0;
            end
        endcase
    end

    // Truth bank: cleared on sweep start, one bit written per sample point.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_truth
            localparam logic [WIDTH-1:0] IDX = WIDTH'(gi);
            assign truth_next[gi] = start_accept ? 1'b0 :
                                    (sample_point && (vec_reg == IDX)) ? sweep.resp_in :
                                    truth_reg[gi];
        end
    endgenerate

    // Sequencer and truth-bank registers; reset discards any partial sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            vec_reg       <= '0;
            dwell_cnt_reg <= '0;
            truth_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            vec_reg       <= vec_next;
            dwell_cnt_reg <= dwell_cnt_next;
            truth_reg     <= truth_next;
        end
    end

`ifdef VEC_GOLDEN_CHECK_EN
    localparam logic [WIDTH:0] ERR_MAX = (WIDTH + 1)'(DEPTH);

    logic           golden;
    logic [WIDTH:0] err_cnt_reg, err_cnt_next;

    // Reference AOI model driven from the current vector {A,B,C,D,E}.
    always_comb begin
        golden = ~(((vec_reg[4] & vec_reg[3]) | vec_reg[2] | vec_reg[1]) & vec_reg[0]);
    end

    // Mismatch counter: cleared at sweep start, saturates at 2**WIDTH.
    always_comb begin
        err_cnt_next = err_cnt_reg;
        if (start_accept) begin
            err_cnt_next = '0;
        end else if (sample_point && (sweep.resp_in != golden) && (err_cnt_reg != ERR_MAX)) begin
            err_cnt_next = err_cnt_reg + 1'b1;
        end
    end

    // Mismatch counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_reg <= '0;
        end else begin
            err_cnt_reg <= err_cnt_next;
        end
    end

    assign sweep.err_cnt = err_cnt_reg;
`else
    assign sweep.err_cnt = '0;
`endif

    assign sweep.vec   = vec_reg;
    assign sweep.busy  = (state_reg == ST_DRIVE);
    assign sweep.done  = (state_reg == ST_FIN);
    assign sweep.truth = truth_reg;
endmodule
